// File: rtl/stress_checker.sv
`default_nettype none
// ============================================================================
//  Module   : stress_checker
//  Purpose  : Locks onto an incrementing stress-counter bus, then counts
//             mismatches and latches a sticky FAIL with a status LED.
//  Revision : 1.0 - initial release
// ============================================================================
module stress_checker #(
  parameter int WIDTH      = 32,
  parameter int SYNC_COUNT = 16,
  parameter int ERR_LIMIT  = 4,
  parameter int BLINK_DIV  = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output logic             locked,
  output logic             fail,
  output logic [15:0]      err_count,
  output logic             led
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   prev_q;
  logic [WIDTH-1:0]   prev_plus1;
  logic [15:0]        sync_cnt_q, sync_cnt_d;
  logic [15:0]        err_cnt_q, err_cnt_d;
  logic [15:0]        sync_inc, err_inc;
  logic [BLINK_DIV:0] blink_q, blink_d;
  logic               locked_q, fail_q, led_q, led_d;
  logic               match;

  // Natural modular wrap makes all-ones followed by zero a match.
  assign prev_plus1 = prev_q + WIDTH'(1);
  assign match      = (data_in == prev_plus1);
  assign sync_inc   = sync_cnt_q + 16'd1;
  assign err_inc    = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
  assign blink_d    = blink_q + {{BLINK_DIV{1'b0}}, 1'b1};

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_SYNC;
          sync_cnt_d = '0;
        end
      end
      ST_SYNC: begin
        if (!enable) begin
          state_d    = ST_IDLE;
          sync_cnt_d = '0;
        end else if (match) begin
          sync_cnt_d = sync_inc;
          if (sync_inc == 16'(SYNC_COUNT)) state_d = ST_CHECK;
        end else begin
          sync_cnt_d = '0;
        end
      end
      ST_CHECK: begin
        if (!enable) begin
          state_d    = ST_IDLE;
          sync_cnt_d = '0;
        end else if (!match) begin
          err_cnt_d = err_inc;
          if (err_inc >= 16'(ERR_LIMIT)) state_d = ST_FAIL;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // LED follows the next state and next blink value so it moves with the state.
  always_comb begin
    led_d = 1'b0;
    case (state_d)
      ST_IDLE:  led_d = 1'b0;
      ST_SYNC:  led_d = blink_d[BLINK_DIV];
      ST_CHECK: led_d = 1'b1;
      ST_FAIL:  led_d = blink_d[BLINK_DIV-2];
      default:  led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prev_q     <= '0;
      sync_cnt_q <= '0;
      err_cnt_q  <= '0;
      blink_q    <= '0;
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= data_in;
      sync_cnt_q <= sync_cnt_d;
      err_cnt_q  <= err_cnt_d;
      blink_q    <= blink_d;
      locked_q   <= (state_d == ST_CHECK);
      fail_q     <= (state_d == ST_FAIL);
      led_q      <= led_d;
    end
  end

  assign locked    = locked_q;
  assign fail      = fail_q;
  assign err_count = err_cnt_q;
  assign led       = led_q;

endmodule
`default_nettype wire

// File: tb/tb_stress_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stress_checker
//  Purpose  : Vector table, corner sequences and random traffic against a
//             behavioural model of the stress checker.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stress_checker;

  localparam int WIDTH      = 8;
  localparam int SYNC_COUNT = 4;
  localparam int ERR_LIMIT  = 2;
  localparam int BLINK_DIV  = 3;

  localparam int M_IDLE  = 0;
  localparam int M_SYNC  = 1;
  localparam int M_CHECK = 2;
  localparam int M_FAIL  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] data_in;
  logic             locked;
  logic             fail;
  logic [15:0]      err_count;
  logic             led;

  always #5 clk = ~clk;

  stress_checker #(
    .WIDTH     (WIDTH),
    .SYNC_COUNT(SYNC_COUNT),
    .ERR_LIMIT (ERR_LIMIT),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .data_in  (data_in),
    .locked   (locked),
    .fail     (fail),
    .err_count(err_count),
    .led      (led)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode, last sample, run length, error total, cycle age.
  int         m_state = M_IDLE;
  logic [7:0] m_prev  = 8'd0;
  int         m_run   = 0;
  int         m_err   = 0;
  int         m_cyc   = 0;

  typedef struct {
    bit         rst;
    bit         en;
    logic [7:0] d;
    int         locked;
    int         fail;
    int         err;
    int         led;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit r, input bit e, input int d,
                              input int l, input int f, input int er, input int ld);
    vecs.push_back('{r, e, 8'(d), l, f, er, ld});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input logic [7:0] d);
    logic [7:0] want;
    want = m_prev + 8'd1;
    if (r) begin
      m_state = M_IDLE; m_prev = 8'd0; m_run = 0; m_err = 0; m_cyc = 0;
    end else begin
      if (m_state == M_IDLE) begin
        if (e) begin m_state = M_SYNC; m_run = 0; end
      end else if (m_state == M_SYNC || m_state == M_CHECK) begin
        if (!e) begin
          m_state = M_IDLE; m_run = 0;
        end else if (m_state == M_SYNC) begin
          m_run = (d == want) ? m_run + 1 : 0;
          if (m_run == SYNC_COUNT) m_state = M_CHECK;
        end else if (d != want) begin
          if (m_err < 65535) m_err++;
          if (m_err >= ERR_LIMIT) m_state = M_FAIL;
        end
      end
      m_prev = d;
      m_cyc  = (m_cyc + 1) % (1 << (BLINK_DIV + 1));
    end
  endtask

  function automatic int exp_led();
    case (m_state)
      M_SYNC:  return (m_cyc / (1 << BLINK_DIV)) % 2;
      M_CHECK: return 1;
      M_FAIL:  return (m_cyc / (1 << (BLINK_DIV - 2))) % 2;
      default: return 0;
    endcase
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_locked"}, locked, (m_state == M_CHECK) ? 1 : 0);
    chk({tag, "_fail"}, fail, (m_state == M_FAIL) ? 1 : 0);
    chk({tag, "_err"}, err_count, m_err);
    chk({tag, "_led"}, led, exp_led());
  endtask

  task automatic step(input bit r, input bit e, input logic [7:0] d);
    reset = r; enable = e; data_in = d;
    @(posedge clk);
    model_step(r, e, d);
    #1;
  endtask

  initial begin
    int         toggles;
    logic       last_led;
    logic [7:0] gen;
    bit         r, e;
    logic [7:0] d;

    reset = 1'b1; enable = 1'b0; data_in = 8'd0;

    // Lock from zero
    add(1,0,0, 0,0,0,0);
    add(0,1,0, 0,0,0,-1); add(0,1,1, 0,0,0,-1); add(0,1,2, 0,0,0,-1);
    add(0,1,3, 0,0,0,-1); add(0,1,4, 1,0,0,1);  add(0,1,5, 1,0,0,1);
    // Lock just below the wrap point, then cross it
    add(1,0,0, 0,0,0,0);
    add(0,1,8'hF9, 0,0,0,-1); add(0,1,8'hFA, 0,0,0,-1); add(0,1,8'hFB, 0,0,0,-1);
    add(0,1,8'hFC, 0,0,0,-1); add(0,1,8'hFD, 1,0,0,1);  add(0,1,8'hFE, 1,0,0,1);
    add(0,1,8'hFF, 1,0,0,1);  add(0,1,8'h00, 1,0,0,1);  add(0,1,8'h01, 1,0,0,1);
    // Resync after a mismatch in SYNC
    add(1,0,0, 0,0,0,0);
    add(0,1,0, 0,0,0,-1); add(0,1,1, 0,0,0,-1); add(0,1,2, 0,0,0,-1);
    add(0,1,7, 0,0,0,-1); add(0,1,8, 0,0,0,-1); add(0,1,9, 0,0,0,-1);
    add(0,1,10, 0,0,0,-1); add(0,1,11, 1,0,0,1);
    // Two glitches drive FAIL, which then ignores data and enable
    add(1,0,0, 0,0,0,0);
    add(0,1,0, 0,0,0,-1); add(0,1,1, 0,0,0,-1); add(0,1,2, 0,0,0,-1);
    add(0,1,3, 0,0,0,-1); add(0,1,4, 1,0,0,1);  add(0,1,5, 1,0,0,1);
    add(0,1,40, 1,0,1,1); add(0,1,41, 1,0,1,1); add(0,1,99, 0,1,2,-1);
    add(0,1,100, 0,1,2,-1); add(0,1,7, 0,1,2,-1); add(0,0,0, 0,1,2,-1);
    add(0,0,50, 0,1,2,-1); add(0,1,51, 0,1,2,-1);
    // Enable drop holds err_count, then relock
    add(1,0,0, 0,0,0,0);
    add(0,1,0, 0,0,0,-1); add(0,1,1, 0,0,0,-1); add(0,1,2, 0,0,0,-1);
    add(0,1,3, 0,0,0,-1); add(0,1,4, 1,0,0,1);  add(0,1,20, 1,0,1,1);
    add(0,1,21, 1,0,1,1); add(0,0,0, 0,0,1,0);  add(0,0,9, 0,0,1,0);
    add(0,1,0, 0,0,1,-1); add(0,1,1, 0,0,1,-1); add(0,1,2, 0,0,1,-1);
    add(0,1,3, 0,0,1,-1); add(0,1,4, 1,0,1,1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].d);
      if (vecs[i].locked >= 0) chk($sformatf("tbl%0d_locked", i), locked, vecs[i].locked);
      if (vecs[i].fail   >= 0) chk($sformatf("tbl%0d_fail", i), fail, vecs[i].fail);
      if (vecs[i].err    >= 0) chk($sformatf("tbl%0d_err", i), err_count, vecs[i].err);
      if (vecs[i].led    >= 0) chk($sformatf("tbl%0d_led", i), led, vecs[i].led);
      check_model($sformatf("tbl%0d", i));
    end

    // Push into FAIL from the relocked state and watch the fast blink
    step(0, 1, 8'd200);
    chk("enter_fail", fail, 1);
    last_led = led; toggles = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1'($urandom_range(0, 1)), 8'($urandom));
      check_model("fail_hold");
      if (led !== last_led) toggles++;
      last_led = led;
    end
    chk("fail_blink_toggles", toggles, 4);

    // Reset out of FAIL clears everything
    step(1, 1, 8'd33);
    chk("rst_fail_locked", locked, 0);
    chk("rst_fail_fail", fail, 0);
    chk("rst_fail_err", err_count, 0);
    chk("rst_fail_led", led, 0);

    // Constant data keeps SYNC unlocked; the slow blink toggles twice per 16 cycles
    step(0, 1, 8'd0);
    check_model("sync_entry");
    last_led = led; toggles = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'd0);
      check_model("sync_hold");
      if (led !== last_led) toggles++;
      last_led = led;
    end
    chk("sync_blink_toggles", toggles, 2);

    // Random traffic with occasional glitches, enable drops and resets
    gen = 8'd0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 29) != 0);
      if (!e) gen = 8'd0;
      else    gen = gen + 8'd1;
      d = ($urandom_range(0, 15) == 0) ? 8'($urandom) : gen;
      step(r, e, d);
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
